// File: rtl/spi_slave_frame.sv
// spi_slave_frame: SPI slave frame engine with configurable frame width and SPI mode.
//
// Receives MOSI frames MSB first and presents them on rx_data when a frame
// completes. At the same time it shifts a transmit frame out on MISO, MSB first.
// The transmit frame comes from a single-entry shadow register. If the shadow is
// empty when the frame starts, the previous frame is sent again.
//
// Parameters
//   FRAME_W      bits per frame (>= 8)
//   CPOL         idle level of sclk
//   CPHA         0: sample on leading edge, shift on trailing edge
//                1: shift on leading edge, sample on trailing edge
//   SYNC_STAGES  synchroniser depth on sclk, mosi and cs (>= 2)
//
// Ports
//   clk          system clock (sclk must be at most clk/8)
//   reset        synchronous, active-low
//   sclk, mosi   SPI clock and master data (asynchronous)
//   cs           chip select, active-low (asynchronous)
//   miso         slave data out; 0 when not selected
//   miso_oe      high while a frame is active
//   tx_data      next MISO frame
//   tx_load      pulse: capture tx_data into the shadow
//   tx_req       pulse: the shadow was consumed at frame start
//   tx_underrun  pulse: a frame started with the shadow empty
//   rx_data      last complete MOSI frame
//   rx_valid     pulse: rx_data updated
//   frame_err    pulse: cs rose after 1..FRAME_W-1 sampled bits

module spi_slave_frame #(
  parameter int unsigned FRAME_W     = 32,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sclk,
  input  logic               mosi,
  input  logic               cs,
  output logic               miso,
  output logic               miso_oe,
  input  logic [FRAME_W-1:0] tx_data,
  input  logic               tx_load,
  output logic               tx_req,
  output logic               tx_underrun,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err
);

  localparam int unsigned CntW = $clog2(FRAME_W + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(FRAME_W);

  typedef enum logic [1:0] {
    StArm,
    StIdle,
    StActive
  } state_e;

  state_e state_q, state_d;

  // Synchronisers and edge history
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sclk_hist_q;
  logic                   cs_hist_q;

  logic sclk_s, mosi_s, cs_s;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise;

  // Datapath state
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic               shadow_full_q, shadow_full_d;
  logic [FRAME_W-1:0] last_tx_q, last_tx_d;
  logic [FRAME_W-1:0] shift_tx_q, shift_tx_d;
  logic [FRAME_W-1:0] shift_rx_q, shift_rx_d;
  logic [CntW-1:0]    bit_cnt_q, bit_cnt_d;
  logic               first_shift_q, first_shift_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               tx_req_q, tx_req_d;
  logic               tx_underrun_q, tx_underrun_d;
  logic               rx_valid_q, rx_valid_d;
  logic               frame_err_q, frame_err_d;

  logic frame_start, frame_end;

  // cs chain resets to 0 so that ARM only leaves once a real deselect has
  // propagated through the synchroniser.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_sync_q <= {SYNC_STAGES{CPOL}};
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_hist_q <= CPOL;
      cs_hist_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
    end
  end

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead_edge   = (sclk_hist_q == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_hist_q != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  assign cs_fall = cs_hist_q & ~cs_s;
  assign cs_rise = ~cs_hist_q & cs_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StArm;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StArm: begin
        if (cs_s) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (cs_fall) begin
          state_d = StActive;
        end
      end
      StActive: begin
        if (cs_rise) begin
          state_d = StIdle;
        end
      end
      default: state_d = StArm;
    endcase
  end

  // FSM outputs
  always_comb begin
    frame_start = 1'b0;
    frame_end   = 1'b0;
    miso        = 1'b0;
    miso_oe     = 1'b0;
    case (state_q)
      StIdle: begin
        frame_start = cs_fall;
      end
      StActive: begin
        frame_end = cs_rise;
        miso_oe   = 1'b1;
        // With CPHA=1 the LSB is done once the last bit is sampled; the
        // register would only clear on the next leading edge.
        miso      = shift_tx_q[FRAME_W-1] & ~(CPHA && (bit_cnt_q == FullCnt));
      end
      default: ;
    endcase
  end

  // Datapath next state
  always_comb begin
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    last_tx_d     = last_tx_q;
    shift_tx_d    = shift_tx_q;
    shift_rx_d    = shift_rx_q;
    bit_cnt_d     = bit_cnt_q;
    first_shift_d = first_shift_q;
    rx_data_d     = rx_data_q;
    tx_req_d      = 1'b0;
    tx_underrun_d = 1'b0;
    rx_valid_d    = 1'b0;
    frame_err_d   = 1'b0;

    if (frame_start) begin
      if (shadow_full_q) begin
        shift_tx_d = shadow_q;
        last_tx_d  = shadow_q;
        tx_req_d   = 1'b1;
      end else begin
        shift_tx_d    = last_tx_q;
        tx_underrun_d = 1'b1;
      end
      shadow_full_d = 1'b0;
      bit_cnt_d     = '0;
      first_shift_d = 1'b1;
    end else if (frame_end) begin
      if (bit_cnt_q == FullCnt) begin
        rx_data_d  = shift_rx_q;
        rx_valid_d = 1'b1;
      end else if (bit_cnt_q != '0) begin
        frame_err_d = 1'b1;
      end
    end else if (state_q == StActive) begin
      // Bits beyond FRAME_W are dropped and the counter saturates.
      if (sample_edge && (bit_cnt_q < FullCnt)) begin
        shift_rx_d = {shift_rx_q[FRAME_W-2:0], mosi_s};
        bit_cnt_d  = bit_cnt_q + CntW'(1);
      end
      if (shift_edge) begin
        // CPHA=1: the first leading edge only presents the MSB.
        if (CPHA && first_shift_q) begin
          first_shift_d = 1'b0;
        end else begin
          shift_tx_d = {shift_tx_q[FRAME_W-2:0], 1'b0};
        end
      end
    end

    // Applied after frame start so a coincident load refills the shadow.
    if (tx_load) begin
      shadow_d      = tx_data;
      shadow_full_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      last_tx_q     <= '0;
      shift_tx_q    <= '0;
      shift_rx_q    <= '0;
      bit_cnt_q     <= '0;
      first_shift_q <= 1'b0;
      rx_data_q     <= '0;
      tx_req_q      <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      last_tx_q     <= last_tx_d;
      shift_tx_q    <= shift_tx_d;
      shift_rx_q    <= shift_rx_d;
      bit_cnt_q     <= bit_cnt_d;
      first_shift_q <= first_shift_d;
      rx_data_q     <= rx_data_d;
      tx_req_q      <= tx_req_d;
      tx_underrun_q <= tx_underrun_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign tx_req      = tx_req_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_frame.sv
// Bench for spi_slave_frame: one 32-bit mode-0 instance and three 16-bit instances
// in modes 1, 2 and 3 sharing one chip select. Expected pulses are queued as
// stimulus is issued and matched as the DUTs raise them.

module tb_spi_slave_frame;

  localparam int KRx   = 0;
  localparam int KErr  = 1;
  localparam int KReq  = 2;
  localparam int KUnd  = 3;
  localparam int KNone = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        sclk_base, sclk_inv, mosi, cs_a, cs_b;
  logic [31:0] tx32;
  logic [15:0] tx16;
  logic        ld_a, ld_b;
  logic [3:0]  miso_v, oe_v, req_v, und_v, rv_v, fe_v;
  logic [31:0] rx0;
  logic [15:0] rx1, rx2, rx3;

  assign sclk_inv = ~sclk_base;

  spi_slave_frame #(.FRAME_W(32), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u0 (
    .clk(clk), .reset(reset), .sclk(sclk_base), .mosi(mosi), .cs(cs_a),
    .miso(miso_v[0]), .miso_oe(oe_v[0]), .tx_data(tx32), .tx_load(ld_a),
    .tx_req(req_v[0]), .tx_underrun(und_v[0]), .rx_data(rx0), .rx_valid(rv_v[0]),
    .frame_err(fe_v[0])
  );

  spi_slave_frame #(.FRAME_W(16), .CPOL(1'b0), .CPHA(1'b1), .SYNC_STAGES(2)) u1 (
    .clk(clk), .reset(reset), .sclk(sclk_base), .mosi(mosi), .cs(cs_b),
    .miso(miso_v[1]), .miso_oe(oe_v[1]), .tx_data(tx16), .tx_load(ld_b),
    .tx_req(req_v[1]), .tx_underrun(und_v[1]), .rx_data(rx1), .rx_valid(rv_v[1]),
    .frame_err(fe_v[1])
  );

  spi_slave_frame #(.FRAME_W(16), .CPOL(1'b1), .CPHA(1'b0), .SYNC_STAGES(2)) u2 (
    .clk(clk), .reset(reset), .sclk(sclk_inv), .mosi(mosi), .cs(cs_b),
    .miso(miso_v[2]), .miso_oe(oe_v[2]), .tx_data(tx16), .tx_load(ld_b),
    .tx_req(req_v[2]), .tx_underrun(und_v[2]), .rx_data(rx2), .rx_valid(rv_v[2]),
    .frame_err(fe_v[2])
  );

  spi_slave_frame #(.FRAME_W(16), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u3 (
    .clk(clk), .reset(reset), .sclk(sclk_inv), .mosi(mosi), .cs(cs_b),
    .miso(miso_v[3]), .miso_oe(oe_v[3]), .tx_data(tx16), .tx_load(ld_b),
    .tx_req(req_v[3]), .tx_underrun(und_v[3]), .rx_data(rx3), .rx_valid(rv_v[3]),
    .frame_err(fe_v[3])
  );

  typedef struct {
    int          idx;
    int          kind;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    int          grp;
    logic        ld;
    logic [31:0] tx;
    logic [31:0] mosi_w;
    int          nbits;
    int          start_k;
    logic [31:0] exp_miso;
    int          end_k;
    logic [31:0] exp_rx;
  } row_t;

  ev_t         exp_q[$];
  row_t        rows[11];
  logic [31:0] cap[4];
  int          extra_nz;
  int          oe_bad;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [31:0] rx_of(input int k);
    case (k)
      0:       return rx0;
      1:       return {16'h0000, rx1};
      2:       return {16'h0000, rx2};
      default: return {16'h0000, rx3};
    endcase
  endfunction

  function automatic logic pulse_of(input int k, input int kind);
    case (kind)
      KRx:     return rv_v[k];
      KErr:    return fe_v[k];
      KReq:    return req_v[k];
      default: return und_v[k];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int k, input int kind, input logic [31:0] data);
    ev_t e;
    e.idx  = k;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Advances one clock and scores every output pulse against the queue.
  task automatic tick();
    ev_t e;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      for (int kind = 0; kind < 4; kind++) begin
        if (pulse_of(k, kind)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(k * 16 + kind), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("pulse_id", 32'(k * 16 + kind), 32'(e.idx * 16 + e.kind));
            if (kind <= KErr) check("rx_data", rx_of(k), e.data);
          end
        end
      end
    end
  endtask

  task automatic sclk_cycle(input logic b);
    mosi = b;
    repeat (4) tick();
    sclk_base = 1'b1;
    repeat (8) tick();
    sclk_base = 1'b0;
    repeat (4) tick();
  endtask

  task automatic run_frame(input int grp, input logic [31:0] mosi_w, input int nbits,
                           input logic late_ld, input logic [31:0] late_data);
    int w;
    int lo;
    int hi;
    w  = (grp == 0) ? 32 : 16;
    lo = (grp == 0) ? 0 : 1;
    hi = (grp == 0) ? 0 : 3;
    for (int k = 0; k < 4; k++) cap[k] = '0;
    extra_nz = 0;
    oe_bad   = 0;
    if (grp == 0) cs_a = 1'b0;
    else cs_b = 1'b0;
    tick();
    tick();
    // Load lands in the same cycle the frame start is detected.
    if (late_ld) begin
      if (grp == 0) begin
        tx32 = late_data;
        ld_a = 1'b1;
      end else begin
        tx16 = late_data[15:0];
        ld_b = 1'b1;
      end
    end
    tick();
    ld_a = 1'b0;
    ld_b = 1'b0;
    repeat (5) tick();
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < w) ? mosi_w[w-1-i] : 1'b0;
      repeat (4) tick();
      sclk_base = 1'b1;
      repeat (7) tick();
      for (int k = lo; k <= hi; k++) begin
        if (i < w) cap[k] = {cap[k][30:0], miso_v[k]};
        else if (miso_v[k]) extra_nz++;
        if (!oe_v[k]) oe_bad++;
      end
      tick();
      sclk_base = 1'b0;
      repeat (4) tick();
    end
    repeat (4) tick();
    if (grp == 0) cs_a = 1'b1;
    else cs_b = 1'b1;
    repeat (8) tick();
    for (int k = lo; k <= hi; k++) begin
      check("idle_miso_oe", {30'h0, miso_v[k], oe_v[k]}, 32'h0);
    end
  endtask

  task automatic apply_row(input row_t r);
    int lo;
    int hi;
    lo = (r.grp == 0) ? 0 : 1;
    hi = (r.grp == 0) ? 0 : 3;
    if (r.ld) begin
      if (r.grp == 0) begin
        tx32 = r.tx;
        ld_a = 1'b1;
      end else begin
        tx16 = r.tx[15:0];
        ld_b = 1'b1;
      end
      tick();
      ld_a = 1'b0;
      ld_b = 1'b0;
      tick();
    end
    for (int k = lo; k <= hi; k++) push_ev(k, r.start_k, 32'h0);
    if (r.end_k != KNone) begin
      for (int k = lo; k <= hi; k++) push_ev(k, r.end_k, r.exp_rx);
    end
    run_frame(r.grp, r.mosi_w, r.nbits, 1'b0, 32'h0);
    for (int k = lo; k <= hi; k++) begin
      check("miso_word", cap[k], r.exp_miso);
    end
    check("miso_tail_zero", 32'(extra_nz), 32'h0);
    check("miso_oe_active", 32'(oe_bad), 32'h0);
    check("events_pending", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    rows[0]  = '{0, 1'b0, 32'h0,         32'h0F0F_0F0F, 32, KUnd, 32'h0,         KRx,   32'h0F0F_0F0F};
    rows[1]  = '{0, 1'b1, 32'hA5A5_0F0F, 32'h1234_5678, 32, KReq, 32'hA5A5_0F0F, KRx,   32'h1234_5678};
    rows[2]  = '{0, 1'b0, 32'h0,         32'hDEAD_BEEF, 32, KUnd, 32'hA5A5_0F0F, KRx,   32'hDEAD_BEEF};
    rows[3]  = '{0, 1'b1, 32'h5A5A_1234, 32'h8765_4321, 32, KReq, 32'h5A5A_1234, KRx,   32'h8765_4321};
    rows[4]  = '{0, 1'b0, 32'h0,         32'hFFFF_FFFF, 13, KUnd, 32'h0000_0B4B, KErr,  32'h8765_4321};
    rows[5]  = '{0, 1'b0, 32'h0,         32'hCAFE_F00D, 40, KUnd, 32'h5A5A_1234, KRx,   32'hCAFE_F00D};
    rows[6]  = '{0, 1'b0, 32'h0,         32'h0,         0,  KUnd, 32'h0,         KNone, 32'h0};
    rows[7]  = '{1, 1'b0, 32'h0,         32'h0000_1357, 16, KUnd, 32'h0,         KRx,   32'h0000_1357};
    rows[8]  = '{1, 1'b1, 32'h0000_BEEF, 32'h0000_C0DE, 16, KReq, 32'h0000_BEEF, KRx,   32'h0000_C0DE};
    rows[9]  = '{1, 1'b0, 32'h0,         32'h0000_A5C3, 20, KUnd, 32'h0000_BEEF, KRx,   32'h0000_A5C3};
    rows[10] = '{1, 1'b0, 32'h0,         32'h0000_F800, 5,  KUnd, 32'h0000_0017, KErr,  32'h0000_A5C3};

    reset     = 1'b0;
    sclk_base = 1'b0;
    mosi      = 1'b0;
    cs_a      = 1'b1;
    cs_b      = 1'b1;
    tx32      = '0;
    tx16      = '0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    repeat (5) tick();
    for (int k = 0; k < 4; k++) begin
      check("reset_outputs", {26'h0, miso_v[k], oe_v[k], req_v[k], und_v[k], rv_v[k], fe_v[k]},
            32'h0);
      check("reset_rx_data", rx_of(k), 32'h0);
    end
    reset = 1'b1;
    repeat (6) tick();

    for (int r = 0; r < 11; r++) apply_row(rows[r]);

    // Load coincident with frame start: old shadow goes out, new one is kept.
    tx32 = 32'h2222_2222;
    ld_a = 1'b1;
    tick();
    ld_a = 1'b0;
    tick();
    push_ev(0, KReq, 32'h0);
    push_ev(0, KRx, 32'h0000_0001);
    run_frame(0, 32'h0000_0001, 32, 1'b1, 32'h1111_1111);
    check("late_load_frame", cap[0], 32'h2222_2222);
    push_ev(0, KReq, 32'h0);
    push_ev(0, KRx, 32'h0000_0002);
    run_frame(0, 32'h0000_0002, 32, 1'b0, 32'h0);
    check("late_load_next", cap[0], 32'h1111_1111);
    check("events_pending", 32'(exp_q.size()), 32'h0);

    // Reset in the middle of a frame with a fresh load pending in the shadow.
    push_ev(0, KUnd, 32'h0);
    cs_a = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 5; i++) sclk_cycle(1'b1);
    tx32 = 32'h3333_3333;
    ld_a = 1'b1;
    tick();
    ld_a = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    check("midrst_outputs", {26'h0, miso_v[0], oe_v[0], req_v[0], und_v[0], rv_v[0], fe_v[0]},
          32'h0);
    check("midrst_rx_u0", rx_of(0), 32'h0);
    check("midrst_rx_u1", rx_of(1), 32'h0);
    reset = 1'b1;
    repeat (4) tick();
    // Frame still in progress after reset release must be ignored.
    for (int i = 0; i < 5; i++) sclk_cycle(1'b0);
    check("arm_miso_oe", {30'h0, miso_v[0], oe_v[0]}, 32'h0);
    cs_a = 1'b1;
    repeat (10) tick();
    check("events_pending", 32'(exp_q.size()), 32'h0);
    push_ev(0, KUnd, 32'h0);
    push_ev(0, KRx, 32'h600D_F00D);
    run_frame(0, 32'h600D_F00D, 32, 1'b0, 32'h0);
    check("post_reset_miso", cap[0], 32'h0);
    check("events_pending", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_frame.md
# spi_slave_frame

Parametrised SPI slave frame engine, successor to the fixed 32-bit slave. Supports a configurable frame width, all four SPI modes, a double-buffered transmit shadow with underrun reporting, and frame-length error detection. Sits between the external SPI master (MCU) and the tracking logic. The tracking logic loads enemy-position frames for MISO and receives motor-command frames from MOSI.

## Interface
- `FRAME_W`, 32: bits per frame, ≥8, MSB first on both lines.
- `CPOL`, 0: idle level of `sclk`.
- `CPHA`, 0: 0 = sample on leading edge, shift on trailing; 1 = shift on leading edge, sample on trailing.
- `SYNC_STAGES`, 2: synchroniser flops on `sclk`, `mosi` and `cs`; ≥2.

Ports:
- `clk` in 1: system clock. `sclk` ≤ `clk`/8.
- `reset` in 1: synchronous, active-low.
- `sclk` in 1: SPI clock, asynchronous.
- `mosi` in 1: master data out, asynchronous.
- `cs` in 1: chip select, active-low, asynchronous.
- `miso` out 1: slave data out. 0 when not selected.
- `miso_oe` out 1: 1 while the frame is active (pad tristate control).
- `tx_data` in FRAME_W: next MISO frame.
- `tx_load` in 1: 1-cycle pulse that captures `tx_data` into the shadow.
- `tx_req` out 1: 1-cycle pulse when the shadow has been consumed at frame start.
- `tx_underrun` out 1: 1-cycle pulse when a frame starts with the shadow empty.
- `rx_data` out FRAME_W: last complete MOSI frame; held until the next complete frame.
- `rx_valid` out 1: 1-cycle pulse when `rx_data` updates.
- `frame_err` out 1: 1-cycle pulse when `cs` rises after 1..FRAME_W-1 sampled bits.

## Operation
- Synchronisation:
  - `sclk`, `mosi` and `cs` pass through SYNC_STAGES flops.
  - Edges are detected on the synchronised `sclk` with one extra history flop.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
- FSM states: ARM, IDLE, ACTIVE.
  - ARM (after reset): wait until synchronised `cs`=1, then go to IDLE. A frame already in progress at reset release is ignored.
  - IDLE → ACTIVE on a synchronised `cs` falling edge.
    - On that cycle: shift_tx ← shadow if shadow_full, else last_tx (the previous frame, resent); shadow_full ← 0.
    - Pulse `tx_req` if the shadow was full; otherwise pulse `tx_underrun`.
    - bit_cnt ← 0.
  - ACTIVE, sample edge:
    - If bit_cnt < FRAME_W: shift_rx ← {shift_rx[FRAME_W-2:0], mosi_sync} and bit_cnt++.
    - If bit_cnt = FRAME_W: extra bits are ignored and bit_cnt saturates at FRAME_W.
  - ACTIVE, shift edge:
    - shift_tx ← shift_tx << 1.
    - When CPHA=1, the first leading edge presents the MSB and does not shift.
    - After FRAME_W bits, `miso` drives 0.
  - ACTIVE → IDLE on a synchronised `cs` rising edge:
    - bit_cnt = FRAME_W: rx_data ← shift_rx and pulse `rx_valid`.
    - bit_cnt = 1..FRAME_W-1: pulse `frame_err`; rx_data unchanged.
    - bit_cnt = 0: no pulse.
- `miso` = shift_tx[FRAME_W-1] in ACTIVE, else 0. With CPHA=0 the MSB is valid from the cycle ACTIVE is entered.
- Shadow:
  - `tx_load` sets shadow ← tx_data and shadow_full ← 1 in any state.
  - A load while the shadow is full overwrites it (last write wins).
  - `tx_load` in the same cycle as frame start: the frame uses the previous shadow (or last_tx if empty). The new data stays in the shadow, and shadow_full ends at 1.
- last_tx is updated with every frame actually transmitted.

## Timing
- Reset values:
  - Outputs: `miso`, `miso_oe`, `tx_req`, `tx_underrun`, `rx_valid`, `frame_err` = 0; `rx_data` = 0.
  - Internal: shadow, last_tx = 0; shadow_full = 0; FSM = ARM.
- `cs` pin falling edge → ACTIVE (`miso_oe`=1, `tx_req`/`tx_underrun` pulse): SYNC_STAGES+1 clk.
- `sclk` pin edge → shift/sample action: SYNC_STAGES+1 clk. Worst-case `miso` lag behind the `sclk` pin is SYNC_STAGES+2 clk.
- `cs` pin rising edge → `rx_valid`/`frame_err`: SYNC_STAGES+1 clk. Output pulses are exactly 1 clk wide.
- `rx_valid` and `frame_err` are mutually exclusive. `tx_req` and `tx_underrun` are mutually exclusive.
- Reset asserted mid-frame: abort with no pulses, return to ARM, discard the shadow.

## Test plan
1. Mode 0, FRAME_W=32. `tx_load` 0xA5A5_0F0F, then a frame with MOSI 0x1234_5678:
   - MISO shifts out 0xA5A5_0F0F.
   - `rx_data`=0x1234_5678 and one `rx_valid`.
   - One `tx_req`.
2. Modes 1, 2 and 3, FRAME_W=16, same exchange with 0xBEEF/0xC0DE: bit-exact in every mode.
3. Frame with no prior `tx_load`:
   - `tx_underrun` pulses and MISO resends the previous frame (0 after reset).
   - A second load then frame: `tx_req`, no underrun.
4. `cs` rises after 13 of 32 bits: `frame_err` once, `rx_data` unchanged, no `rx_valid`. A 40-clock frame delivers the first 32 bits with `rx_valid`.
5. `tx_load` 0x1111_1111 coincident with the `cs`-fall detect while the shadow holds 0x2222_2222:
   - This frame sends 0x2222_2222; the next sends 0x1111_1111.
   - Then `reset`=0 mid-frame: all outputs return to 0, and no pulse occurs until `cs` goes high then low again.
